lsu_unit: RTL and testbench

Load/store unit directly downstream of the ALU in the single-core RISC-V datapath.
- Takes the ALU's 32-bit result as the effective address and the rs2 value as store data.
- Runs a valid/ready transaction to data memory and returns a sign- or zero-extended load result for writeback.
- Holds `busy` high to stall the core while the access is in flight.

---
 rtl/lsu_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lsu_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit between the ALU and data memory: one valid/ready beat per access, load data extended for writeback.
// Latency: store 2 cycles from capture to done with mem_ready high; load 2 cycles plus memory read latency.
// Backpressure: holds mem_valid and request fields until mem_ready; busy stalls the core for the whole access.
//
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   req_valid/req_write/req_size/   core request; held until done
//   req_unsigned/addr/wdata
//   busy, done, rdata, misaligned   stall, completion pulse, load result, misaligned-reject flag
//   mem_valid/mem_ready/mem_we/     data memory request channel (word-aligned address, byte enables)
//   mem_addr/mem_wdata/mem_be
//   mem_rvalid/mem_rdata            data memory read return
//
// Optional build macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses are split into
// two word beats (REQ2/WAIT2) instead of being rejected; misaligned is then tied low.

module lsu_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    REQ2  = 3'd4,
    WAIT2 = 3'd5
  } state_t;

  state_t state;

  // Captured request attributes needed after the IDLE cycle.
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       unsigned_q;
  logic       write_q;

  // Sign/zero extension of a right-justified byte/half; word passes through.
  function automatic logic [31:0] extend(input logic [31:0] v,
                                         input logic [1:0]  sz,
                                         input logic        uns);
    logic [31:0] r;
    case (sz)
      2'b00:   r = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Request decode, valid only while sampled in IDLE.
  logic [1:0]            off;
  logic [3:0]            base_be;
  logic [3:0]            be_lo;
  logic                  req_mis;
  logic [31:0]           rep_data;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign off       = addr[1:0];
  assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign be_lo     = base_be << off;

  always_comb begin
    base_be  = 4'b1111;
    rep_data = wdata;
    req_mis  = 1'b0;
    case (req_size)
      2'b00: begin
        base_be  = 4'b0001;
        rep_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        base_be  = 4'b0011;
        rep_data = {2{wdata[15:0]}};
        req_mis  = off[0];
      end
      default: begin
        req_mis  = (off != 2'b00);
      end
    endcase
  end

  // Load lane select: move the addressed lane down to bit 0.
  logic [5:0]  rd_sh;
  logic [31:0] lane_data;
  assign rd_sh     = {1'b0, off_q, 3'b000};
  assign lane_data = mem_rdata >> rd_sh;

`ifdef LSU_MISALIGN_SPLIT_EN
  // Split path: beat 1 carries lanes off..3 of word W, beat 2 the spill into word W+4.
  logic [5:0]  wr_sh;
  logic [31:0] rot_data;
  logic [3:0]  be_hi;
  logic [3:0]  be2_q;
  logic        split_q;
  logic [31:0] beat1_q;
  logic [31:0] joined;

  assign wr_sh    = {1'b0, off, 3'b000};
  // off is never 0 on the split path, so the complementary shift stays below 32.
  assign rot_data = (wdata << wr_sh) | (wdata >> (6'd32 - wr_sh));
  assign be_hi    = base_be >> (3'd4 - {1'b0, off});
  assign joined   = (beat1_q >> rd_sh) | (mem_rdata << (6'd32 - rd_sh));
  assign misaligned = 1'b0;
`else
  logic misaligned_q;
  assign misaligned = misaligned_q;
`endif

  assign busy = (state == REQ) || (state == WAIT) || (state == REQ2) ||
                (state == WAIT2) || ((state == IDLE) && req_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'b0000;
      rdata      <= 32'h0;
      done       <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      be2_q      <= 4'b0000;
      split_q    <= 1'b0;
      beat1_q    <= 32'h0;
`else
      misaligned_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifndef LSU_MISALIGN_SPLIT_EN
      misaligned_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q      <= off;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            write_q    <= req_write;
            if (!req_mis) begin
              mem_valid <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= word_addr;
              mem_be    <= be_lo;
              mem_wdata <= rep_data;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_q   <= 1'b0;
`endif
              state     <= REQ;
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
              mem_valid <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= word_addr;
              mem_be    <= be_lo;
              mem_wdata <= rot_data;
              be2_q     <= be_hi;
              split_q   <= 1'b1;
              state     <= REQ;
`else
              // Rejected: no memory beat, loads return zero.
              if (!req_write) rdata <= 32'h0;
              done         <= 1'b1;
              misaligned_q <= 1'b1;
              state        <= RESP;
`endif
            end
          end
        end

        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!write_q) begin
              state <= WAIT;
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
              if (split_q) begin
                mem_valid <= 1'b1;
                mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                mem_be    <= be2_q;
                state     <= REQ2;
              end else begin
                done  <= 1'b1;
                state <= RESP;
              end
`else
              done  <= 1'b1;
              state <= RESP;
`endif
            end
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (split_q) begin
              beat1_q   <= mem_rdata;
              mem_valid <= 1'b1;
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_be    <= be2_q;
              state     <= REQ2;
            end else begin
              rdata <= extend(lane_data, size_q, unsigned_q);
              done  <= 1'b1;
              state <= RESP;
            end
`else
            rdata <= extend(lane_data, size_q, unsigned_q);
            done  <= 1'b1;
            state <= RESP;
`endif
          end
        end

`ifdef LSU_MISALIGN_SPLIT_EN
        REQ2: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (write_q) begin
              done  <= 1'b1;
              state <= RESP;
            end else begin
              state <= WAIT2;
            end
          end
        end

        WAIT2: begin
          if (mem_rvalid) begin
            rdata <= extend(joined, size_q, unsigned_q);
            done  <= 1'b1;
            state <= RESP;
          end
        end
`endif

        // done was raised on entry; return to IDLE without capturing.
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: drives core requests, plays a small word memory,
// and compares observed memory beats, timing and load results against hand-computed values.

module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem_model [0:255];

  // Per-access observations.
  int          nb;
  int          nvalid;
  int          stable_err;
  int          done_cyc;
  logic        done_seen;
  logic        mis_seen;
  logic        busy_at_done;
  logic        done_next;
  logic [31:0] beat_addr [4];
  logic [3:0]  beat_be   [4];
  logic [31:0] beat_wd   [4];
  logic        beat_we   [4];

  // Entered at a falling edge; cycle 0 is the capture cycle.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input int stall);
    int          cyc;
    int          stall_left;
    logic        pend_rd;
    logic [31:0] pend_addr;
    logic        in_beat;
    logic [31:0] s_addr;
    logic [31:0] s_wd;
    logic [3:0]  s_be;
    logic        s_we;
    nb = 0; nvalid = 0; stable_err = 0; done_cyc = -1;
    done_seen = 1'b0; mis_seen = 1'b0; busy_at_done = 1'b1; done_next = 1'b1;
    stall_left = stall; pend_rd = 1'b0; pend_addr = 32'h0; in_beat = 1'b0;
    s_addr = 32'h0; s_wd = 32'h0; s_be = 4'h0; s_we = 1'b0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    addr = a; wdata = d;
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      #1;
      mem_rvalid = pend_rd;
      mem_rdata  = pend_rd ? mem_model[pend_addr[9:2]] : 32'h0BAD0BAD;
      pend_rd    = 1'b0;
      if (done) begin
        done_seen = 1'b1; done_cyc = cyc; mis_seen = misaligned; busy_at_done = busy;
        req_valid = 1'b0;
      end
      if (mem_valid) begin
        nvalid++;
        if (!busy) stable_err++;
        if (in_beat) begin
          if (mem_addr !== s_addr || mem_wdata !== s_wd || mem_be !== s_be || mem_we !== s_we)
            stable_err++;
        end else begin
          in_beat = 1'b1;
          s_addr = mem_addr; s_wd = mem_wdata; s_be = mem_be; s_we = mem_we;
        end
        mem_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (mem_ready) begin
          if (nb < 4) begin
            beat_addr[nb] = mem_addr; beat_be[nb] = mem_be;
            beat_wd[nb]   = mem_wdata; beat_we[nb] = mem_we;
          end
          nb++;
          in_beat = 1'b0;
          stall_left = stall;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_model[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
          end else begin
            pend_rd = 1'b1; pend_addr = mem_addr;
          end
        end
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
    #1 done_next = done;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", mem_be, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: aligned word store, ready already high.
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    check("t1_done", done_seen, 1);
    check("t1_nvalid", nvalid, 1);
    check("t1_addr", beat_addr[0], 32'h100);
    check("t1_be", beat_be[0], 4'b1111);
    check("t1_wdata", beat_wd[0], 32'hDEADBEEF);
    check("t1_we", beat_we[0], 1);
    check("t1_done_cyc", done_cyc, 2);
    check("t1_busy_resp", busy_at_done, 0);
    check("t1_done_1cyc", done_next, 0);
    check("t1_mis", mis_seen, 0);

    // 2: byte load from lane 3, signed then unsigned.
    mem_model[32'h100 >> 2] = 32'h80FFFFFF;
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0);
    check("t2s_done", done_seen, 1);
    check("t2s_addr", beat_addr[0], 32'h100);
    check("t2s_be", beat_be[0], 4'b1000);
    check("t2s_we", beat_we[0], 0);
    check("t2s_done_cyc", done_cyc, 3);
    check("t2s_rdata", rdata, 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0);
    check("t2u_rdata", rdata, 32'h00000080);

    // 3: half store to upper half; rdata untouched by stores.
    run_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 0);
    check("t3_addr", beat_addr[0], 32'h200);
    check("t3_be", beat_be[0], 4'b1100);
    check("t3_wdata", beat_wd[0], 32'hABCDABCD);
    check("t3_done_cyc", done_cyc, 2);
    check("t3_rdata_kept", rdata, 32'h00000080);

    // 4: mem_ready low for 3 cycles, store then byte store then load.
    run_req(1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344, 3);
    check("t4s_nvalid", nvalid, 4);
    check("t4s_stable", stable_err, 0);
    check("t4s_done_cyc", done_cyc, 5);
    run_req(1'b1, 2'b00, 1'b0, 32'h301, 32'h0000005A, 0);
    check("t4b_be", beat_be[0], 4'b0010);
    check("t4b_wdata", beat_wd[0], 32'h5A5A5A5A);
    check("t4b_mem", mem_model[32'h300 >> 2], 32'h11225A44);
    mem_model[32'h300 >> 2] = 32'h87654321;
    run_req(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 3);
    check("t4l_nvalid", nvalid, 4);
    check("t4l_stable", stable_err, 0);
    check("t4l_done_cyc", done_cyc, 6);
    check("t4l_rdata", rdata, 32'hFFFF8765);

    // Size 11 behaves as word.
    run_req(1'b1, 2'b11, 1'b0, 32'h3F0, 32'hCAFE1234, 0);
    check("sz3_be", beat_be[0], 4'b1111);
    check("sz3_wdata", beat_wd[0], 32'hCAFE1234);

    // 5: misaligned word load and store.
    mem_model[32'h100 >> 2] = 32'h44332211;
    mem_model[32'h104 >> 2] = 32'h88776655;
`ifdef LSU_MISALIGN_SPLIT_EN
    run_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0);
    check("t5_nb", nb, 2);
    check("t5_addr0", beat_addr[0], 32'h100);
    check("t5_be0", beat_be[0], 4'b1110);
    check("t5_addr1", beat_addr[1], 32'h104);
    check("t5_be1", beat_be[1], 4'b0001);
    check("t5_rdata", rdata, 32'h55443322);
    check("t5_done_cyc", done_cyc, 5);
    check("t5_done_1cyc", done_next, 0);
    check("t5_mis", mis_seen, 0);
    run_req(1'b1, 2'b10, 1'b0, 32'h106, 32'hAABBCCDD, 0);
    check("t5s_nb", nb, 2);
    check("t5s_be0", beat_be[0], 4'b1100);
    check("t5s_be1", beat_be[1], 4'b0011);
    check("t5s_wd", beat_wd[0], 32'hCCDDAABB);
    check("t5s_mem", mem_model[32'h104 >> 2], 32'hCCDD6655);
    check("t5s_rdata_kept", rdata, 32'h55443322);
    mem_model[32'h104 >> 2] = 32'h88776655;
`else
    run_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0);
    check("t5_done", done_seen, 1);
    check("t5_nvalid", nvalid, 0);
    check("t5_mis", mis_seen, 1);
    check("t5_rdata", rdata, 32'h0);
    check("t5_done_cyc", done_cyc, 1);
    check("t5_done_1cyc", done_next, 0);
    run_req(1'b1, 2'b10, 1'b0, 32'h106, 32'hAABBCCDD, 0);
    check("t5s_nvalid", nvalid, 0);
    check("t5s_mis", mis_seen, 1);
    check("t5s_mem", mem_model[32'h104 >> 2], 32'h88776655);
    run_req(1'b0, 2'b01, 1'b1, 32'h201, 32'h0, 0);
    check("t5h_mis", mis_seen, 1);
    check("t5h_nvalid", nvalid, 0);
`endif

    // 6: reset while in WAIT, then a late read return.
    run_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0);
    check("t6_pre_rdata", rdata, 32'h88776655);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h100;
    @(negedge clk);                       // cycle 1: REQ
    #1 mem_ready = 1'b1;
    check("t6_req_valid", mem_valid, 1);
    @(negedge clk);                       // cycle 2: WAIT
    #1 mem_ready = 1'b0; reset = 1'b1; req_valid = 1'b0;
    check("t6_wait_busy", busy, 1);
    @(negedge clk);                       // cycle 3: IDLE after reset
    #1 reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    check("t6_mem_valid", mem_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done_a", done, 0);
    @(negedge clk);
    #1 mem_rvalid = 1'b0;
    check("t6_done_b", done, 0);
    check("t6_rdata", rdata, 32'h0);
    check("t6_mem_valid_b", mem_valid, 0);
    @(negedge clk);

    // Recovery after reset.
    run_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 0);
    check("t7_done", done_seen, 1);
    check("t7_rdata", rdata, 32'h00000011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
